param_sequence_detector: RTL and testbench
==========================================

# param_sequence_detector

Run-time programmable serial bit-pattern detector. It generalises the fixed 101101 Mealy/Moore detector to any pattern of 1..MAX_LEN bits, loaded at run time. It adds an input qualifier, selectable overlapping or non-overlapping detection, and a saturating match counter. It sits on the serial input path between the bit source and the control logic that consumes detection pulses.

## Interface
- MAX_LEN, 16: maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1): width of `len` and `fill` (derived; do not override).
- CNT_W, 8: match counter width.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cfg_load  in  1  pulse; captures `pattern`/`len` and restarts detection.
- pattern  in  MAX_LEN  target sequence; pattern[len-1] is the first bit received, pattern[0] the last.
- len  in  LEN_W  pattern length; 0 disables detection; values > MAX_LEN clamp to MAX_LEN.
- X  in  1  serial data bit.
- x_valid  in  1  X is sampled only when 1.
- M  in  1  output mode: 0 = Mealy, 1 = Moore.
- overlap  in  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- clr_count  in  1  synchronous clear of `match_count`.
- Z  out  1  detection output (see Timing).
- fill  out  LEN_W  valid bits currently held in history, saturating at the active length.
- match_count  out  CNT_W  number of matches, saturating.

## Operation
- Registers: `pat_r`[MAX_LEN], `len_r`[LEN_W], history shift register `hist`[MAX_LEN] (newest bit at hist[0]), `fill`, `z_moore`, `match_count`.
- Reset: pat_r=0, len_r=0 (detection disabled), hist=0, fill=0, z_moore=0, match_count=0; Z=0.
- cfg_load=1 at an edge: pat_r<=pattern, len_r<=clamp(len), hist<=0, fill<=0, z_moore<=0. X is ignored that cycle and no match is counted. match_count is not affected.
- Candidate window: cand = {hist[MAX_LEN-2:0], X}.
- Match condition `hit` (combinational): x_valid & ~cfg_load & (len_r!=0) & (fill+1 >= len_r) & (cand[len_r-1:0] == pat_r[len_r-1:0]).
- On an edge with x_valid=1 and cfg_load=0:
  - hist<=cand.
  - fill<=min(fill+1, len_r).
  - If hit and overlap=0: fill<=0. hist is still shifted, but the bits are unusable until fill refills.
  - If hit: match_count<=match_count+1, saturating at 2^CNT_W-1.
- x_valid=0: hist, fill and z_moore hold, except that z_moore clears.
- clr_count=1: match_count<=0. clr_count takes priority over a simultaneous increment.
- Both output paths are always computed. M only selects the output, so switching M mid-stream loses no history.

## Timing
- Mealy (M=0): Z = hit, combinational. Z is high during the cycle in which the final pattern bit is presented, before the edge that samples it. Z is zero latency and may glitch while X settles.
- Moore (M=1): Z = z_moore, where z_moore<=hit at each edge. Z rises one clock after the Mealy pulse, is glitch-free, and is high for exactly one cycle per match.
- match_count updates at the same edge that loads z_moore.
- Back-to-back matches with overlap=1 (e.g. len 1) give Z high on consecutive cycles.
- Reset asserted mid-stream: all state clears immediately and asynchronously. The first match after release needs len_r new bits after a fresh cfg_load; len_r=0 after reset means no detection until configured.
- A pattern longer than the bits received so far never matches (fill gate). A stale hist after cfg_load cannot alias.

## Test plan
- Config pattern=6'b101101, len=6, M=1, overlap=1; stream 101101101101 with x_valid=1 → Moore Z pulses after bits 6, 9 and 12; match_count=3.
- Same stream with overlap=0 → Z pulses after bits 6 and 12 only; match_count=2.
- M=0, same config, X changed on negedge → Z high in the half-cycle before the posedge sampling bits 6, 9 and 12, with Z==hit. Toggling M mid-stream does not lose the next match.
- x_valid gaps: insert x_valid=0 cycles between each bit of 101101 → exactly one match, and Z stays 0 during the gaps.
- CNT_W=2, len=1, pattern=1, stream of 6 ones → match_count saturates at 3. clr_count with a simultaneous hit → match_count=0.
- Reset mid-pattern (after bits 1011) then reconfigure len=4, pattern=4'b1101 and stream 1101 → one match, no aliasing with pre-reset bits. len=0 → Z never asserts. len=20 with MAX_LEN=16 → clamps to 16.

Source files
------------

// File: rtl/param_sequence_detector_if.sv
// Bundle between a serial bit source/configurator and the pattern detector.
// Master drives configuration and data; slave returns detection status.
interface param_sequence_detector_if #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               X;
    logic               x_valid;
    logic               M;
    logic               overlap;
    logic               clr_count;
    logic               Z;
    logic [LEN_W-1:0]   fill;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output cfg_load, pattern, len, X, x_valid, M, overlap, clr_count,
        input  Z, fill, match_count
    );

    modport slave (
        input  cfg_load, pattern, len, X, x_valid, M, overlap, clr_count,
        output Z, fill, match_count
    );
endinterface

// File: rtl/param_sequence_detector.sv
// Run-time programmable serial pattern detector with Mealy/Moore output,
// optional overlapping matches and a saturating match counter.
module param_sequence_detector #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8
) (
    input logic                      clk,
    input logic                      reset,
    param_sequence_detector_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] pat_r;
    logic [MAX_LEN-2:0] hist;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   fill_r;
    logic               z_moore;
    logic [CNT_W-1:0]   cnt_r;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len_clamp;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_next;
    logic               fill_ok;
    logic               hit;

    assign len_clamp = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN)
                                                   : bus.len;

    // Oldest history bit falls off; only MAX_LEN-1 past bits plus X matter.
    assign cand = {hist, bus.X};

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_r));
    end

    assign fill_inc  = {1'b0, fill_r} + (LEN_W + 1)'(1);
    assign fill_ok   = (fill_inc >= {1'b0, len_r});
    assign fill_next = (fill_r == len_r) ? fill_r : fill_inc[LEN_W-1:0];

    assign hit = bus.x_valid & ~bus.cfg_load & (len_r != '0) & fill_ok &
                 ((cand & mask) == (pat_r & mask));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_r   <= '0;
            len_r   <= '0;
            hist    <= '0;
            fill_r  <= '0;
            z_moore <= 1'b0;
            cnt_r   <= '0;
        end else begin
            if (bus.cfg_load) begin
                pat_r   <= bus.pattern;
                len_r   <= len_clamp;
                hist    <= '0;
                fill_r  <= '0;
                z_moore <= 1'b0;
            end else if (bus.x_valid) begin
                hist    <= cand[MAX_LEN-2:0];
                fill_r  <= (hit && !bus.overlap) ? '0 : fill_next;
                z_moore <= hit;
            end else begin
                z_moore <= 1'b0;
            end

            if (bus.clr_count)
                cnt_r <= '0;
            else if (hit && (cnt_r != '1))
                cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign bus.Z           = bus.M ? z_moore : hit;
    assign bus.fill        = fill_r;
    assign bus.match_count = cnt_r;
endmodule

// File: tb/tb_param_sequence_detector.sv
// Bench for param_sequence_detector: two instances (8-bit and 2-bit counters)
// share stimulus and are compared against a queue-based reference model.
module tb_param_sequence_detector;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    param_sequence_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(8)) b8 ();
    param_sequence_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(2)) b2 ();

    assign b2.cfg_load  = b8.cfg_load;
    assign b2.pattern   = b8.pattern;
    assign b2.len       = b8.len;
    assign b2.X         = b8.X;
    assign b2.x_valid   = b8.x_valid;
    assign b2.M         = b8.M;
    assign b2.overlap   = b8.overlap;
    assign b2.clr_count = b8.clr_count;

    param_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    param_sequence_detector #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: bits received since the last restart, newest last.
    bit                 q[$];
    int                 m_len;
    logic [MAX_LEN-1:0] m_pat;
    bit                 m_zm;
    int                 m_c8;
    int                 m_c2;

    bit                 cur_m;
    bit                 cur_ov;
    logic [MAX_LEN-1:0] cur_pat;
    logic [LEN_W-1:0]   cur_len;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit();
        bit b;
        if (!b8.x_valid || b8.cfg_load || m_len == 0) return 1'b0;
        if (q.size() + 1 < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            b = (i == 0) ? bit'(b8.X) : q[q.size() - i];
            if (b != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_len = 0;
        m_pat = '0;
        m_zm  = 1'b0;
        m_c8  = 0;
        m_c2  = 0;
    endtask

    task automatic step(input bit cfg, input bit x, input bit xv,
                        input bit clr);
        bit h;
        @(negedge clk);
        b8.cfg_load  = cfg;
        b8.X         = x;
        b8.x_valid   = xv;
        b8.clr_count = clr;
        b8.M         = cur_m;
        b8.overlap   = cur_ov;
        b8.pattern   = cur_pat;
        b8.len       = cur_len;
        #1;
        h = model_hit();
        if (!cur_m) begin
            chk("mealy_z8", b8.Z, h);
            chk("mealy_z2", b2.Z, h);
        end else begin
            chk("moore_z8", b8.Z, m_zm);
            chk("moore_z2", b2.Z, m_zm);
        end
        @(posedge clk);
        #1;
        if (cfg) begin
            m_pat = cur_pat;
            m_len = (int'(cur_len) > MAX_LEN) ? MAX_LEN : int'(cur_len);
            q.delete();
            m_zm  = 1'b0;
        end else if (xv) begin
            q.push_back(x);
            if (h && !cur_ov) q.delete();
            while (q.size() > MAX_LEN) void'(q.pop_front());
            m_zm = h;
        end else begin
            m_zm = 1'b0;
        end
        if (clr) begin
            m_c8 = 0;
            m_c2 = 0;
        end else if (h) begin
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3) m_c2++;
        end
        chk("fill8", b8.fill, min_i(q.size(), m_len));
        chk("fill2", b2.fill, min_i(q.size(), m_len));
        chk("cnt8", b8.match_count, m_c8);
        chk("cnt2", b2.match_count, m_c2);
        if (cur_m) chk("moore_z_post", b8.Z, m_zm);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            step(1'b0, bits[i], 1'b1, 1'b0);
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] p,
                             input logic [LEN_W-1:0] l);
        cur_pat = p;
        cur_len = l;
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset        = 1'b0;
        b8.cfg_load  = 1'b0;
        b8.pattern   = '0;
        b8.len       = '0;
        b8.X         = 1'b0;
        b8.x_valid   = 1'b0;
        b8.M         = 1'b1;
        b8.overlap   = 1'b1;
        b8.clr_count = 1'b0;
        cur_m   = 1'b1;
        cur_ov  = 1'b1;
        cur_pat = '0;
        cur_len = '0;
        model_reset();

        // Reset state
        #3;
        chk("rst_fill", b8.fill, 0);
        chk("rst_cnt", b8.match_count, 0);
        chk("rst_z_moore", b8.Z, 0);
        b8.M = 1'b0;
        b8.X = 1'b1;
        b8.x_valid = 1'b1;
        #1;
        chk("rst_z_mealy", b8.Z, 0);
        b8.x_valid = 1'b0;
        #3;
        reset = 1'b1;

        // Moore, overlapping
        cur_m  = 1'b1;
        cur_ov = 1'b1;
        configure(16'b101101, 5'd6);
        send_bits(32'b101101101101, 12);
        chk("moore_ov_cnt", b8.match_count, 3);

        // Moore, non-overlapping
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cur_ov = 1'b0;
        configure(16'b101101, 5'd6);
        send_bits(32'b101101101101, 12);
        chk("moore_nov_cnt", b8.match_count, 2);

        // Mealy with M toggled mid-stream
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cur_m  = 1'b0;
        cur_ov = 1'b1;
        configure(16'b101101, 5'd6);
        send_bits(32'b101101, 6);
        cur_m = 1'b1;
        send_bits(32'b10, 2);
        cur_m = 1'b0;
        send_bits(32'b1101101, 7);
        chk("mealy_cnt", b8.match_count, 4);

        // x_valid gaps between every bit
        step(1'b0, 1'b0, 1'b0, 1'b1);
        cur_m = 1'b1;
        configure(16'b101101, 5'd6);
        for (int i = 5; i >= 0; i--) begin
            step(1'b0, cur_pat[i], 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("gap_cnt", b8.match_count, 1);

        // Saturation and clear-vs-hit priority
        step(1'b0, 1'b0, 1'b0, 1'b1);
        configure(16'b1, 5'd1);
        send_bits(32'b111111, 6);
        chk("sat_cnt2", b2.match_count, 3);
        chk("cnt8_six", b8.match_count, 6);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_hit_cnt8", b8.match_count, 0);
        chk("clr_hit_cnt2", b2.match_count, 0);

        // Asynchronous reset mid-pattern, then reconfigure
        configure(16'b101101, 5'd6);
        send_bits(32'b1011, 4);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("amid_fill", b8.fill, 0);
        chk("amid_cnt8", b8.match_count, 0);
        chk("amid_cnt2", b2.match_count, 0);
        chk("amid_z", b8.Z, 0);
        @(negedge clk);
        reset = 1'b1;
        configure(16'b1101, 5'd4);
        send_bits(32'b1101, 4);
        chk("post_rst_cnt", b8.match_count, 1);

        // len=0 disables detection in both modes
        step(1'b0, 1'b0, 1'b0, 1'b1);
        configure(16'hFFFF, 5'd0);
        for (int i = 0; i < 10; i++) begin
            cur_m = bit'(i % 2);
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
        chk("len0_cnt", b8.match_count, 0);

        // len=20 clamps to MAX_LEN
        cur_m = 1'b1;
        configure(16'hA5C3, 5'd20);
        send_bits(32'h0, 20);
        chk("clamp_fill", b8.fill, 16);
        send_bits(32'hA5C3, 16);
        chk("clamp_cnt", b8.match_count, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                cur_pat = MAX_LEN'($urandom);
                cur_len = ($urandom_range(0, 3) == 0)
                        ? LEN_W'($urandom_range(0, 20))
                        : LEN_W'($urandom_range(1, 4));
                step(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                if ($urandom_range(0, 29) == 0) cur_m = ~cur_m;
                if ($urandom_range(0, 29) == 0) cur_ov = ~cur_ov;
                step(1'b0, 1'($urandom), ($urandom_range(0, 4) != 0),
                     ($urandom_range(0, 49) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
